// File: rtl/ahb3lite_mem_responder.sv
// AHB3-Lite slave memory with programmable wait states, byte-lane writes and two-cycle ERROR responses.
// Define AHB_MEM_NOP_INIT_EN to make HRESET load every word with a NOP (32'h0000_0013).
module ahb3lite_mem_responder #(
    parameter int          MEM_DEPTH   = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0200,
    parameter int          WAIT_STATES = 0
) (
    input  logic                         HCLK,
    input  logic                         HRESET,
    input  logic                         HSEL,
    input  logic [31:0]                  HADDR,
    input  logic                         HWRITE,
    input  logic [2:0]                   HSIZE,
    input  logic [1:0]                   HTRANS,
    input  logic [31:0]                  HWDATA,
    input  logic                         HREADY,
    output logic [31:0]                  HRDATA,
    output logic                         HREADYOUT,
    output logic                         HRESP,
    input  logic                         ld_we,
    input  logic [$clog2(MEM_DEPTH)-1:0] ld_addr,
    input  logic [31:0]                  ld_data
);

    localparam int          AW        = $clog2(MEM_DEPTH);
    localparam logic [32:0] MEM_BYTES = 33'(MEM_DEPTH) << 2;
    localparam logic [2:0]  WS_LAST   = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    typedef enum logic [2:0] {S_IDLE, S_ERR1, S_ERR2, S_WAIT, S_DATA} state_t;

    state_t        state;
    logic [31:0]   mem [MEM_DEPTH];
    logic [31:0]   offset;
    logic          in_range;
    logic          misaligned;
    logic          req_err;
    logic          accept;
    logic          commit;
    logic [3:0]    req_be;
    logic [AW-1:0] req_idx;
    logic [AW-1:0] rd_idx;
    logic [31:0]   rd_word;
    logic [AW-1:0] cur_idx;
    logic [3:0]    cur_be;
    logic          cur_write;
    logic [2:0]    wait_cnt;
    logic          unused_trans;

    assign unused_trans = HTRANS[0];

    // Decode the address phase; the read word bypasses a write committing on the same edge.
    always_comb begin
        offset     = HADDR - BASE_ADDR;
        in_range   = (HADDR >= BASE_ADDR) && ({1'b0, offset} < MEM_BYTES);
        req_idx    = offset[AW+1:2];
        req_be     = 4'b0000;
        misaligned = 1'b0;
        case (HSIZE)
            3'd0: req_be = 4'b0001 << HADDR[1:0];
            3'd1: begin
                req_be     = HADDR[1] ? 4'b1100 : 4'b0011;
                misaligned = HADDR[0];
            end
            3'd2: begin
                req_be     = 4'b1111;
                misaligned = |HADDR[1:0];
            end
            default: req_be = 4'b0000;
        endcase
        req_err = (HSIZE > 3'd2) || misaligned || !in_range;
        accept  = HSEL && HREADY && HTRANS[1] &&
                  (state == S_IDLE || state == S_DATA || state == S_ERR2);
        commit  = (state == S_DATA) && cur_write && HREADYOUT;
        rd_idx  = accept ? req_idx : cur_idx;
        rd_word = mem[rd_idx];
        for (int b = 0; b < 4; b++) begin
            if (commit && cur_be[b] && (cur_idx == rd_idx)) begin
                rd_word[8*b +: 8] = HWDATA[8*b +: 8];
            end
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state     <= S_IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
            HRDATA    <= 32'h0;
            wait_cnt  <= 3'd0;
            cur_idx   <= '0;
            cur_be    <= 4'b0000;
            cur_write <= 1'b0;
        end else if (accept) begin
            cur_idx   <= req_idx;
            cur_be    <= req_be;
            cur_write <= HWRITE;
            if (req_err) begin
                state     <= S_ERR1;
                HREADYOUT <= 1'b0;
                HRESP     <= 1'b1;
            end else if (WAIT_STATES == 0) begin
                state     <= S_DATA;
                HREADYOUT <= 1'b1;
                HRESP     <= 1'b0;
                if (!HWRITE) begin
                    HRDATA <= rd_word;
                end
            end else begin
                state     <= S_WAIT;
                wait_cnt  <= WS_LAST;
                HREADYOUT <= 1'b0;
                HRESP     <= 1'b0;
            end
        end else begin
            case (state)
                S_ERR1: begin
                    state     <= S_ERR2;
                    HREADYOUT <= 1'b1;
                    HRESP     <= 1'b1;
                end
                S_WAIT: begin
                    if (wait_cnt == 3'd0) begin
                        state     <= S_DATA;
                        HREADYOUT <= 1'b1;
                        if (!cur_write) begin
                            HRDATA <= rd_word;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    HREADYOUT <= 1'b1;
                    HRESP     <= 1'b0;
                end
            endcase
        end
    end

    // AHB lanes are written after the backdoor word so they win on a same-word collision.
`ifdef AHB_MEM_NOP_INIT_EN
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= 32'h0000_0013;
            end
        end else begin
            if (ld_we) begin
                mem[ld_addr] <= ld_data;
            end
            if (commit) begin
                for (int b = 0; b < 4; b++) begin
                    if (cur_be[b]) begin
                        mem[cur_idx][8*b +: 8] <= HWDATA[8*b +: 8];
                    end
                end
            end
        end
    end
`else
    always_ff @(posedge HCLK) begin
        if (ld_we) begin
            mem[ld_addr] <= ld_data;
        end
        if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (cur_be[b]) begin
                    mem[cur_idx][8*b +: 8] <= HWDATA[8*b +: 8];
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_ahb3lite_mem_responder.sv
// Directed self-checking bench for ahb3lite_mem_responder: one instance with no wait states, one with two.
module tb_ahb3lite_mem_responder;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        sel0;
    logic        sel2;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic [31:0] HWDATA;
    logic        ld_we;
    logic [7:0]  ld_addr;
    logic [31:0] ld_data;
    logic [31:0] rdata0;
    logic [31:0] rdata2;
    logic        ro0;
    logic        ro2;
    logic        resp0;
    logic        resp2;
    logic [31:0] post_reset_w3;
    int          err_count   = 0;
    int          check_count = 0;

    always #5 HCLK = ~HCLK;

    ahb3lite_mem_responder #(.MEM_DEPTH(256), .BASE_ADDR(32'h0000_0200), .WAIT_STATES(0)) dut0 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(sel0), .HADDR(HADDR), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HTRANS(HTRANS), .HWDATA(HWDATA), .HREADY(ro0),
        .HRDATA(rdata0), .HREADYOUT(ro0), .HRESP(resp0),
        .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    ahb3lite_mem_responder #(.MEM_DEPTH(256), .BASE_ADDR(32'h0000_0200), .WAIT_STATES(2)) dut2 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(sel2), .HADDR(HADDR), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HTRANS(HTRANS), .HWDATA(HWDATA), .HREADY(ro2),
        .HRDATA(rdata2), .HREADYOUT(ro2), .HRESP(resp2),
        .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            err_count++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic applyStimulus(input logic use_dut2, input logic [31:0] addr, input logic write,
                                 input logic [2:0] size, input logic [1:0] trans);
        sel0   = !use_dut2;
        sel2   = use_dut2;
        HADDR  = addr;
        HWRITE = write;
        HSIZE  = size;
        HTRANS = trans;
    endtask

    task automatic idleBus();
        sel0   = 1'b0;
        sel2   = 1'b0;
        HWRITE = 1'b0;
        HTRANS = T_IDLE;
    endtask

    task automatic backdoorLoad(input logic [7:0] idx, input logic [31:0] data);
        ld_we   = 1'b1;
        ld_addr = idx;
        ld_data = data;
        tick();
        ld_we   = 1'b0;
    endtask

    task automatic writeOne(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] data);
        applyStimulus(1'b0, addr, 1'b1, size, T_NONSEQ);
        tick();
        idleBus();
        HWDATA = data;
        tick();
    endtask

    task automatic readCheck0(input string tag, input logic [31:0] addr, input logic [31:0] expected);
        applyStimulus(1'b0, addr, 1'b0, 3'd2, T_NONSEQ);
        tick();
        idleBus();
        checkOutput({tag, "_ready"}, 32'(ro0), 32'd1);
        checkOutput({tag, "_resp"}, 32'(resp0), 32'd0);
        checkOutput({tag, "_data"}, rdata0, expected);
    endtask

    task automatic errorCheck0(input string tag, input logic [31:0] addr, input logic write, input logic [2:0] size);
        applyStimulus(1'b0, addr, write, size, T_NONSEQ);
        tick();
        idleBus();
        HWDATA = 32'hFFFF_FFFF;
        checkOutput({tag, "_err1"}, {30'd0, resp0, ro0}, 32'b10);
        tick();
        checkOutput({tag, "_err2"}, {30'd0, resp0, ro0}, 32'b11);
        tick();
        checkOutput({tag, "_idle"}, {30'd0, resp0, ro0}, 32'b01);
    endtask

    initial begin
        HRESET = 1'b1;
        sel0 = 1'b0; sel2 = 1'b0; HADDR = 32'h0; HWRITE = 1'b0; HSIZE = 3'd0;
        HTRANS = T_IDLE; HWDATA = 32'h0; ld_we = 1'b0; ld_addr = 8'd0; ld_data = 32'h0;
        repeat (3) tick();
        checkOutput("rst_ready0", 32'(ro0), 32'd1);
        checkOutput("rst_resp0", 32'(resp0), 32'd0);
        checkOutput("rst_data0", rdata0, 32'h0);
        checkOutput("rst_ready2", 32'(ro2), 32'd1);
        HRESET = 1'b0;
        tick();

        backdoorLoad(8'd5, 32'hDEAD_BEEF);
        readCheck0("rd_0x214", 32'h214, 32'hDEAD_BEEF);

        // Two wait states: HREADYOUT low for exactly two sampled cycles.
        backdoorLoad(8'd0, 32'h1122_3344);
        applyStimulus(1'b1, 32'h200, 1'b0, 3'd2, T_NONSEQ);
        tick();
        idleBus();
        checkOutput("ws_wait1", {30'd0, resp2, ro2}, 32'b00);
        tick();
        checkOutput("ws_wait2", {30'd0, resp2, ro2}, 32'b00);
        tick();
        checkOutput("ws_ready", {30'd0, resp2, ro2}, 32'b01);
        checkOutput("ws_data", rdata2, 32'h1122_3344);

        // Byte write followed immediately by a read of the same word.
        applyStimulus(1'b0, 32'h203, 1'b1, 3'd0, T_NONSEQ);
        tick();
        HWDATA = 32'hAB00_0000;
        applyStimulus(1'b0, 32'h200, 1'b0, 3'd2, T_NONSEQ);
        tick();
        idleBus();
        checkOutput("bypass_ready", 32'(ro0), 32'd1);
        checkOutput("bypass_data", rdata0, 32'hAB22_3344);
        readCheck0("byte_persist", 32'h200, 32'hAB22_3344);

        writeOne(32'h216, 3'd1, 32'h1234_0000);
        readCheck0("half_hi", 32'h214, 32'h1234_BEEF);

        errorCheck0("mis_word", 32'h202, 1'b0, 3'd2);
        errorCheck0("mis_half_wr", 32'h215, 1'b1, 3'd1);
        readCheck0("mis_unchanged", 32'h214, 32'h1234_BEEF);
        errorCheck0("oor_top", 32'h600, 1'b0, 3'd2);
        errorCheck0("oor_below", 32'h1FC, 1'b0, 3'd2);
        errorCheck0("size_big", 32'h200, 1'b0, 3'd3);
        readCheck0("err_mem_ok", 32'h200, 32'hAB22_3344);
        backdoorLoad(8'd255, 32'h0BAD_F00D);
        readCheck0("last_word", 32'h5FC, 32'h0BAD_F00D);

        // AHB byte and backdoor word land on the same word at the same edge.
        applyStimulus(1'b0, 32'h21C, 1'b1, 3'd0, T_NONSEQ);
        tick();
        idleBus();
        HWDATA  = 32'h0000_0055;
        ld_we   = 1'b1;
        ld_addr = 8'd7;
        ld_data = 32'hFFFF_FFFF;
        tick();
        ld_we   = 1'b0;
        readCheck0("collide", 32'h21C, 32'hFFFF_FF55);

        // Reset while a write waits; the write must be dropped.
        backdoorLoad(8'd3, 32'hCAFE_F00D);
        applyStimulus(1'b1, 32'h20C, 1'b1, 3'd2, T_NONSEQ);
        tick();
        idleBus();
        HWDATA = 32'h1234_5678;
        checkOutput("rw_in_wait", 32'(ro2), 32'd0);
        HRESET = 1'b1;
        #1;
        checkOutput("rw_rst_ready", 32'(ro2), 32'd1);
        checkOutput("rw_rst_resp", 32'(resp2), 32'd0);
        checkOutput("rw_rst_data", rdata2, 32'h0);
        tick();
        HRESET = 1'b0;
        tick();
`ifdef AHB_MEM_NOP_INIT_EN
        post_reset_w3 = 32'h0000_0013;
`else
        post_reset_w3 = 32'hCAFE_F00D;
`endif
        applyStimulus(1'b1, 32'h20C, 1'b0, 3'd2, T_NONSEQ);
        tick();
        idleBus();
        tick();
        tick();
        checkOutput("rw_after_ready", 32'(ro2), 32'd1);
        checkOutput("rw_after_data", rdata2, post_reset_w3);
`ifdef AHB_MEM_NOP_INIT_EN
        readCheck0("nop_init", 32'h224, 32'h0000_0013);
`endif

        // Back-to-back pipelined reads.
        backdoorLoad(8'd0, 32'hA0A0_0000);
        backdoorLoad(8'd1, 32'hA1A1_1111);
        backdoorLoad(8'd2, 32'hA2A2_2222);
        applyStimulus(1'b0, 32'h200, 1'b0, 3'd2, T_NONSEQ);
        tick();
        checkOutput("seq0_ready", 32'(ro0), 32'd1);
        checkOutput("seq0_data", rdata0, 32'hA0A0_0000);
        applyStimulus(1'b0, 32'h204, 1'b0, 3'd2, T_SEQ);
        tick();
        checkOutput("seq1_ready", 32'(ro0), 32'd1);
        checkOutput("seq1_data", rdata0, 32'hA1A1_1111);
        applyStimulus(1'b0, 32'h208, 1'b0, 3'd2, T_SEQ);
        tick();
        idleBus();
        checkOutput("seq2_ready", 32'(ro0), 32'd1);
        checkOutput("seq2_data", rdata0, 32'hA2A2_2222);
        tick();
        checkOutput("seq_idle", {30'd0, resp0, ro0}, 32'b01);

        $display("Result: errors=%0d of %0d checks", err_count, check_count);
        $finish;
    end

endmodule
